// File: rtl/ysyx_220053_div_ctrl.sv
// Issue-side controller for the iterative 64-bit divider: decodes RV64M div/rem ops,
// prepares operands, short-circuits divide-by-zero and signed overflow, returns one result per request.
module ysyx_220053_div_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            div_valid,
    output logic            div_signed,
    output logic [XLEN-1:0] dividend,
    output logic [XLEN-1:0] divisor,
    output logic            div_flush,
    input  logic            div_ready,
    input  logic            out_valid,
    input  logic [XLEN-1:0] quotient,
    input  logic [XLEN-1:0] remainder
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

    state_e          state_q;
    logic            rem_q;
    logic            word_q;
    logic            div_signed_q;
    logic [XLEN-1:0] dividend_q;
    logic [XLEN-1:0] divisor_q;
    logic [XLEN-1:0] resp_data_q;

    logic            req_signed;
    logic            req_rem;
    logic [XLEN-1:0] a_prep;
    logic [XLEN-1:0] b_prep;
    logic [XLEN-1:0] min_val;
    logic            is_zero;
    logic            is_ovf;
    logic [XLEN-1:0] special_raw;
    logic [XLEN-1:0] div_raw;

    // W forms return the low word sign-extended regardless of signedness
    function automatic logic [XLEN-1:0] fmt_result(input logic [XLEN-1:0] raw, input logic word);
        fmt_result = word ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;
    endfunction

    assign req_signed = ~req_op[0];
    assign req_rem    = req_op[1];

    always_comb begin
        a_prep = src1;
        b_prep = src2;
        if (req_word) begin
            a_prep = {{(XLEN-32){req_signed & src1[31]}}, src1[31:0]};
            b_prep = {{(XLEN-32){req_signed & src2[31]}}, src2[31:0]};
        end
    end

    assign min_val = req_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign is_zero = (b_prep == '0);
    assign is_ovf  = req_signed && (a_prep == min_val) && (b_prep == '1);

    always_comb begin
        special_raw = '0;
        if (is_zero) begin
            special_raw = req_rem ? a_prep : '1;
        end else begin
            special_raw = req_rem ? '0 : a_prep;
        end
    end

    assign div_raw = rem_q ? remainder : quotient;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rem_q        <= 1'b0;
            word_q       <= 1'b0;
            div_signed_q <= 1'b0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            resp_data_q  <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        rem_q  <= req_rem;
                        word_q <= req_word;
                        if (is_zero || is_ovf) begin
                            resp_data_q <= fmt_result(special_raw, req_word);
                            state_q     <= S_DONE;
                        end else begin
                            dividend_q   <= a_prep;
                            divisor_q    <= b_prep;
                            div_signed_q <= req_signed;
                            state_q      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (div_ready) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (out_valid) begin
                        resp_data_q <= fmt_result(div_raw, word_q);
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (resp_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign div_valid  = (state_q == S_ISSUE);
    assign resp_data  = resp_data_q;
    assign div_signed = div_signed_q;
    assign dividend   = dividend_q;
    assign divisor    = divisor_q;
    assign div_flush  = flush;

endmodule

// File: tb/tb_ysyx_220053_div_ctrl.sv
// Bench for ysyx_220053_div_ctrl: table of directed ops against a behavioural divider
// with configurable latency, plus flush and response back-pressure sequences.
module tb_ysyx_220053_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_word;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        div_valid;
    logic        div_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        div_flush;
    logic        div_ready;
    logic        out_valid;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_220053_div_ctrl #(.XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_word   (req_word),
        .src1       (src1),
        .src2       (src2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .div_valid  (div_valid),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_flush  (div_flush),
        .div_ready  (div_ready),
        .out_valid  (out_valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    // Behavioural divider: fixed latency, optionally deaf to flush to produce a stale pulse
    int          lat = 5;
    logic        ignore_flush = 1'b0;
    logic        busy;
    int          cnt;
    int          issue_cnt;
    logic [63:0] m_a, m_b;
    logic        m_sgn;

    assign div_ready = ~busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            cnt       <= 0;
            issue_cnt <= 0;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            m_a       <= '0;
            m_b       <= '0;
            m_sgn     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (div_flush && !ignore_flush) begin
                busy <= 1'b0;
            end else if (busy) begin
                if (cnt <= 1) begin
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                    if (m_sgn) begin
                        quotient  <= $signed(m_a) / $signed(m_b);
                        remainder <= $signed(m_a) % $signed(m_b);
                    end else begin
                        quotient  <= m_a / m_b;
                        remainder <= m_a % m_b;
                    end
                end else begin
                    cnt <= cnt - 1;
                end
            end else if (div_valid) begin
                busy      <= 1'b1;
                cnt       <= lat;
                issue_cnt <= issue_cnt + 1;
                m_a       <= dividend;
                m_b       <= divisor;
                m_sgn     <= div_signed;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic        special;
        logic [63:0] dvd;
        logic        sgn;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic run_op(input vec_t v);
        int issued_before;
        @(negedge clk);
        chk("req_ready_before", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_word  = v.word;
        src1      = v.a;
        src2      = v.b;
        issued_before = issue_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.special) begin
            chk("special_latency1", {63'd0, resp_valid}, 64'd1);
            chk("special_no_div_valid", {63'd0, div_valid}, 64'd0);
        end else begin
            chk("div_valid_after_accept", {63'd0, div_valid}, 64'd1);
            chk("dividend", dividend, v.dvd);
            chk("div_signed", {63'd0, div_signed}, {63'd0, v.sgn});
        end
        for (int k = 0; k < 200 && !resp_valid; k++) @(negedge clk);
        chk("resp_valid_seen", {63'd0, resp_valid}, 64'd1);
        chk("resp_data", resp_data, v.exp);
        chk("divider_requests", 64'(issue_cnt - issued_before), v.special ? 64'd0 : 64'd1);
        $display("op=%0d word=%0b src1=%h src2=%h -> resp_data=%h (expected %h)",
                 v.op, v.word, v.a, v.b, resp_data, v.exp);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("req_ready_after_resp", {62'd0, req_ready, resp_valid}, 64'd2);
    endtask

    initial begin
        vecs[0]  = '{2'd0, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64'd20, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[1]  = '{2'd2, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64'd20, 1'b1, 64'd2};
        vecs[2]  = '{2'd1, 1'b0, 64'd20, 64'd0, 1'b1, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3]  = '{2'd3, 1'b0, 64'd5, 64'd0, 1'b1, 64'd0, 1'b0, 64'd5};
        vecs[4]  = '{2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b0, 64'd0};
        vecs[5]  = '{2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 64'd0, 1'b0, 64'hFFFF_FFFF_8000_0000};
        vecs[6]  = '{2'd3, 1'b1, 64'h0000_0001_0000_0007, 64'd3, 1'b0, 64'd7, 1'b0, 64'd1};
        vecs[7]  = '{2'd1, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFE, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[8]  = '{2'd0, 1'b0, 64'd100, 64'd7, 1'b0, 64'd100, 1'b1, 64'd14};
        vecs[9]  = '{2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[10] = '{2'd2, 1'b1, 64'h0000_0001_0000_000A, 64'h0000_0005_FFFF_FFFD, 1'b0, 64'd10, 1'b1, 64'd1};
        vecs[11] = '{2'd1, 1'b1, 64'd9, 64'h0000_0001_0000_0000, 1'b1, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[12] = '{2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 64'd0, 1'b0, 64'd0};

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_word = 1'b0;
        src1 = '0; src2 = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_div_valid", {63'd0, div_valid}, 64'd0);
        chk("rst_div_signed", {63'd0, div_signed}, 64'd0);
        chk("rst_operands", dividend | divisor, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_op(vecs[i]);

        // A request coinciding with flush must not be accepted
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd1; req_word = 1'b0; src1 = 64'd50; src2 = 64'd5; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_blocks_accept", {62'd0, req_ready, div_valid}, 64'd2);

        // Flush in WAIT with a divider that still delivers a stale pulse afterwards
        lat = 40; ignore_flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd1; req_word = 1'b0; src1 = 64'd50; src2 = 64'd5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (29) @(negedge clk);
        chk("wait_state_before_flush", {61'd0, req_ready, resp_valid, div_valid}, 64'd0);
        flush = 1'b1;
        #1;
        chk("div_flush_pulse", {63'd0, div_flush}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("idle_after_flush", {62'd0, req_ready, resp_valid}, 64'd2);
        begin
            logic saw_pulse;
            logic stale_resp;
            saw_pulse = 1'b0;
            stale_resp = 1'b0;
            for (int k = 0; k < 60; k++) begin
                if (out_valid) saw_pulse = 1'b1;
                if (resp_valid) stale_resp = 1'b1;
                @(negedge clk);
            end
            if (!saw_pulse) $display("note: stale divider pulse not observed");
            chk("stale_not_returned", {63'd0, stale_resp}, 64'd0);
        end
        ignore_flush = 1'b0; lat = 5;
        run_op('{2'd1, 1'b0, 64'd100, 64'd7, 1'b0, 64'd100, 1'b0, 64'd14});

        // Back-pressure: result must hold while resp_ready stays low
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd1; req_word = 1'b0; src1 = 64'd9; src2 = 64'd2;
        @(posedge clk);
        @(negedge clk);
        req_op = 2'd0; src1 = 64'd77; src2 = 64'd3;
        for (int k = 0; k < 200 && !resp_valid; k++) @(negedge clk);
        begin
            int issued;
            logic stable_bad;
            issued = issue_cnt;
            stable_bad = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (!resp_valid || resp_data !== 64'd4 || req_ready) stable_bad = 1'b1;
                @(negedge clk);
            end
            chk("hold_resp_data", resp_data, 64'd4);
            chk("hold_stable_10", {63'd0, stable_bad}, 64'd0);
            chk("hold_no_new_issue", 64'(issue_cnt - issued), 64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("ready_after_hold", {62'd0, req_ready, resp_valid}, 64'd2);
        $display("backpressure op divu 9/2 -> 4 held 10 cycles");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
